mips_cpu: RTL and testbench

Single-cycle 32-bit MIPS processor core: fetch, decode, execute, memory access and write-back all complete in one clock. It is the top level of the CPU design. It contains the program counter, instruction memory, register file, ALU and byte-addressed big-endian data memory. Programs are loaded into instruction memory by a simulation backdoor. Results are inspected through the register file and data memory arrays.

---
 rtl/mips_cpu.sv | 242 ++++++++++++++++++++++++
 tb/tb_mips_cpu.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu.sv
// mips_cpu: single-cycle 32-bit MIPS core.
// PC, instruction memory, register file, ALU and big-endian data memory.

module mips_cpu #(
    parameter int IM_WORDS = 256,
    parameter int DM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc
);
    localparam int IAW = $clog2(IM_WORDS);
    localparam int DAW = $clog2(DM_BYTES);

    logic [31:0]    instr;
    logic [31:0]    pc4;
    logic [31:0]    next_pc;
    logic [31:0]    rs_v;
    logic [31:0]    rt_v;
    logic [31:0]    sext;
    logic [31:0]    zext;
    logic [31:0]    br_tgt;
    logic [31:0]    j_tgt;
    logic [31:0]    ld_data;
    logic [31:0]    wd;
    logic [5:0]     op;
    logic [5:0]     funct;
    logic [4:0]     rs;
    logic [4:0]     rt;
    logic [4:0]     rd;
    logic [4:0]     shamt;
    logic [4:0]     wa;
    logic [15:0]    imm;
    logic [25:0]    target;
    logic           we;
    logic           mwe;
    logic [DAW-1:0] maddr;

    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign target = instr[25:0];

    assign pc4    = pc + 32'd4;
    assign sext   = {{16{imm[15]}}, imm};
    assign zext   = {16'd0, imm};
    assign br_tgt = pc4 + {sext[29:0], 2'b00};
    assign j_tgt  = {pc4[31:28], target, 2'b00};

    // word-aligned byte address, wrapped to the data memory size
    assign maddr = (rs_v[DAW-1:0] + imm[DAW-1:0]) & ~DAW'(3);

    mips_pc ProgCounter (
        .clk   (clk),
        .reset (reset),
        .next  (next_pc),
        .OUT   (pc)
    );

    mips_imem #(.WORDS(IM_WORDS), .AW(IAW)) IM (
        .addr  (pc[IAW+1:2]),
        .instr (instr)
    );

    mips_rf RF (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rs_v),
        .rd2   (rt_v),
        .we    (we),
        .wa    (wa),
        .wd    (wd)
    );

    mips_dmem #(.BYTES(DM_BYTES), .AW(DAW)) DM (
        .clk   (clk),
        .reset (reset),
        .we    (mwe),
        .addr  (maddr),
        .wdata (rt_v),
        .rdata (ld_data)
    );

    // decode + execute: next PC, register write and store enable
    always_comb begin
        next_pc = pc4;
        we      = 1'b0;
        wa      = rt;
        wd      = '0;
        mwe     = 1'b0;
        unique case (op)
            6'h00: begin
                we = 1'b1;
                wa = rd;
                unique case (funct)
                    6'h20, 6'h21: wd = rs_v + rt_v;
                    6'h22, 6'h23: wd = rs_v - rt_v;
                    6'h24: wd = rs_v & rt_v;
                    6'h25: wd = rs_v | rt_v;
                    6'h26: wd = rs_v ^ rt_v;
                    6'h27: wd = ~(rs_v | rt_v);
                    6'h2A: wd = {31'd0, $signed(rs_v) < $signed(rt_v)};
                    6'h2B: wd = {31'd0, rs_v < rt_v};
                    6'h00: wd = rt_v << shamt;
                    6'h02: wd = rt_v >> shamt;
                    6'h03: wd = $signed(rt_v) >>> shamt;
                    6'h08: begin
                        we      = 1'b0;
                        next_pc = rs_v;
                    end
                    default: we = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin
                we = 1'b1;
                wd = rs_v + sext;
            end
            6'h0A: begin
                we = 1'b1;
                wd = {31'd0, $signed(rs_v) < $signed(sext)};
            end
            6'h0C: begin
                we = 1'b1;
                wd = rs_v & zext;
            end
            6'h0D: begin
                we = 1'b1;
                wd = rs_v | zext;
            end
            6'h0E: begin
                we = 1'b1;
                wd = rs_v ^ zext;
            end
            6'h0F: begin
                we = 1'b1;
                wd = {imm, 16'd0};
            end
            6'h23: begin
                we = 1'b1;
                wd = ld_data;
            end
            6'h2B: mwe = 1'b1;
            6'h04: if (rs_v == rt_v) next_pc = br_tgt;
            6'h05: if (rs_v != rt_v) next_pc = br_tgt;
            6'h02: next_pc = j_tgt;
            6'h03: begin
                next_pc = j_tgt;
                we      = 1'b1;
                wa      = 5'd31;
                wd      = pc4;
            end
            default: ;
        endcase
    end
endmodule

module mips_pc (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next,
    output logic [31:0] OUT
);
    // PC register; reset restarts fetch at address 0
    always_ff @(posedge clk) begin
        if (reset) OUT <= 32'd0;
        else       OUT <= next;
    end
endmodule

module mips_imem #(
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   instr
);
    // contents are placed by a simulation backdoor only
    logic [31:0] InstructionMemory [0:WORDS-1];

    assign instr = InstructionMemory[addr];
endmodule

module mips_rf (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] Registers [0:31];

    // reset clears every register; $0 is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) Registers[i] <= '0;
        end else if (we && wa != 5'd0) begin
            Registers[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : Registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : Registers[ra2];
endmodule

module mips_dmem #(
    parameter int BYTES = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [7:0] DataMemory [0:BYTES-1];

    // big-endian word store, suppressed while reset is high
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            DataMemory[addr]           <= wdata[31:24];
            DataMemory[addr | AW'(1)]  <= wdata[23:16];
            DataMemory[addr | AW'(2)]  <= wdata[15:8];
            DataMemory[addr | AW'(3)]  <= wdata[7:0];
        end
    end

    assign rdata = {DataMemory[addr],
                    DataMemory[addr | AW'(1)],
                    DataMemory[addr | AW'(2)],
                    DataMemory[addr | AW'(3)]};
endmodule

// File: tb/tb_mips_cpu.sv
// tb_mips_cpu: directed programs checked against an instruction-level model.
// Per-cycle PC/register/memory compare plus hand-computed end checks.

module tb_mips_cpu;
    localparam int IMW = 256;
    localparam int DMB = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc;

    int n_cmp = 0;
    int n_bad = 0;
    bit en = 1'b0;

    logic [31:0] m_im  [IMW];
    logic [31:0] m_reg [32];
    logic [7:0]  m_dm  [DMB];
    bit          m_dv  [DMB];
    logic [31:0] m_pc;

    int bi;
    int bd;

    mips_cpu #(.IM_WORDS(IMW), .DM_BYTES(DMB)) dut (
        .clk   (clk),
        .reset (reset),
        .pc    (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ei(int op, int rs, int rt, int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] er(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    function automatic logic [31:0] ej(int op, int addr);
        return {op[5:0], addr[27:2]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dmw(int a);
        return {dut.DM.DataMemory[a], dut.DM.DataMemory[a+1],
                dut.DM.DataMemory[a+2], dut.DM.DataMemory[a+3]};
    endfunction

    // instruction-set model: one architectural instruction per call
    task automatic mstep();
        logic [31:0] ins, a, b, si, zi, v, nxt;
        int op, fn, rs, rt, rd, sh, dst, ad;
        ins = m_im[(m_pc / 4) % IMW];
        op  = int'(ins[31:26]);
        rs  = int'(ins[25:21]);
        rt  = int'(ins[20:16]);
        rd  = int'(ins[15:11]);
        sh  = int'(ins[10:6]);
        fn  = int'(ins[5:0]);
        a   = m_reg[rs];
        b   = m_reg[rt];
        si  = $signed(ins[15:0]);
        zi  = {16'h0, ins[15:0]};
        nxt = m_pc + 4;
        dst = -1;
        v   = 0;
        case (op)
            0: begin
                dst = rd;
                case (fn)
                    'h20, 'h21: v = a + b;
                    'h22, 'h23: v = a - b;
                    'h24: v = a & b;
                    'h25: v = a | b;
                    'h26: v = a ^ b;
                    'h27: v = ~(a | b);
                    'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    'h2B: v = (a < b) ? 32'd1 : 32'd0;
                    'h00: v = b << sh;
                    'h02: v = b >> sh;
                    'h03: v = $signed(b) >>> sh;
                    'h08: begin dst = -1; nxt = a; end
                    default: dst = -1;
                endcase
            end
            'h08, 'h09: begin dst = rt; v = a + si; end
            'h0A: begin dst = rt; v = ($signed(a) < $signed(si)) ? 32'd1 : 32'd0; end
            'h0C: begin dst = rt; v = a & zi; end
            'h0D: begin dst = rt; v = a | zi; end
            'h0E: begin dst = rt; v = a ^ zi; end
            'h0F: begin dst = rt; v = zi * 65536; end
            'h23: begin
                ad  = int'(((a + si) % DMB) / 4 * 4);
                dst = rt;
                v   = {m_dm[ad], m_dm[ad+1], m_dm[ad+2], m_dm[ad+3]};
            end
            'h2B: begin
                ad = int'(((a + si) % DMB) / 4 * 4);
                for (int k = 0; k < 4; k++) begin
                    m_dm[ad+k] = b[31-8*k -: 8];
                    m_dv[ad+k] = 1'b1;
                end
            end
            'h04: if (a == b) nxt = m_pc + 4 + si * 4;
            'h05: if (a != b) nxt = m_pc + 4 + si * 4;
            'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
            'h03: begin
                nxt = {nxt[31:28], ins[25:0], 2'b00};
                dst = 31;
                v   = m_pc + 4;
            end
            default: ;
        endcase
        if (dst > 0) m_reg[dst] = v;
        m_pc = nxt;
    endtask

    // model advances on the same edge as the core
    always @(posedge clk) begin
        if (reset) begin
            m_pc = 0;
            for (int i = 0; i < 32; i++) m_reg[i] = 0;
        end else begin
            mstep();
        end
    end

    // per-cycle architectural state compare
    always @(negedge clk) begin
        if (en) begin
            chk("pc", pc, m_pc);
            n_cmp++;
            bi = -1;
            for (int i = 0; i < 32; i++)
                if (dut.RF.Registers[i] !== m_reg[i]) bi = i;
            if (bi >= 0) begin
                n_bad++;
                $display("FAIL regfile r%0d: got %08h expected %08h",
                         bi, dut.RF.Registers[bi], m_reg[bi]);
            end
            n_cmp++;
            bd = -1;
            for (int i = 0; i < DMB; i++)
                if (m_dv[i] && dut.DM.DataMemory[i] !== m_dm[i]) bd = i;
            if (bd >= 0) begin
                n_bad++;
                $display("FAIL dmem[%0d]: got %02h expected %02h",
                         bd, dut.DM.DataMemory[bd], m_dm[bd]);
            end
        end
    end

    task automatic load(input logic [31:0] prog [$]);
        logic [31:0] w;
        for (int i = 0; i < IMW; i++) begin
            w = (i < prog.size()) ? prog[i] : 32'h0;
            m_im[i] = w;
            dut.IM.InstructionMemory[i] = w;
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart(input logic [31:0] prog [$]);
        reset = 1'b1;
        load(prog);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] p [$];

        // ALU program; extra ops after sll, halt at 0x48
        p = '{ei(8, 0, 8, 5), ei(8, 0, 9, -3),
              er(8, 9, 10, 0, 'h20), er(9, 8, 11, 0, 'h22),
              er(9, 8, 12, 0, 'h2A), er(9, 8, 13, 0, 'h2B),
              er(0, 8, 14, 4, 'h00), er(8, 9, 15, 0, 'h24),
              er(8, 9, 16, 0, 'h25), er(8, 9, 17, 0, 'h26),
              er(8, 9, 18, 0, 'h27), er(0, 9, 19, 4, 'h02),
              er(0, 9, 20, 4, 'h03), ei('h0A, 9, 21, -2),
              ei('h0C, 9, 22, 'hFF00), ei('h0E, 9, 23, 'hFFFF),
              ei('h09, 9, 24, 'h7FFF), er(9, 8, 25, 0, 'h23),
              ej(2, 'h48)};
        load(p);
        @(negedge clk);
        en = 1'b1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_t0", dut.RF.Registers[8], 32'h0);
        reset = 1'b0;
        run(7);
        chk("alu_pc", pc, 32'h1C);
        chk("add", dut.RF.Registers[10], 32'h00000002);
        chk("sub", dut.RF.Registers[11], 32'hFFFFFFF8);
        chk("slt", dut.RF.Registers[12], 32'h00000001);
        chk("sltu", dut.RF.Registers[13], 32'h00000000);
        chk("sll", dut.RF.Registers[14], 32'h00000050);
        run(12);
        chk("alu_halt", pc, 32'h48);
        chk("nor", dut.RF.Registers[18], 32'h00000002);
        chk("srl", dut.RF.Registers[19], 32'h0FFFFFFF);
        chk("sra", dut.RF.Registers[20], 32'hFFFFFFFF);
        chk("slti", dut.RF.Registers[21], 32'h00000001);
        chk("andi", dut.RF.Registers[22], 32'h0000FF00);
        chk("xori", dut.RF.Registers[23], 32'hFFFF0002);
        chk("addiu", dut.RF.Registers[24], 32'h00007FFC);

        // memory program: lui/ori, two stores, load, write to $0
        p = '{ei('h0F, 0, 8, 'h1234), ei('h0D, 8, 8, 'h5678),
              ei('h2B, 0, 8, 8), ei('h2B, 0, 8, 0),
              ei('h23, 0, 9, 8), ei(8, 0, 0, 7), ej(2, 24)};
        restart(p);
        run(7);
        chk("dm8", {24'h0, dut.DM.DataMemory[8]}, 32'h12);
        chk("dm9", {24'h0, dut.DM.DataMemory[9]}, 32'h34);
        chk("dm10", {24'h0, dut.DM.DataMemory[10]}, 32'h56);
        chk("dm11", {24'h0, dut.DM.DataMemory[11]}, 32'h78);
        chk("lw", dut.RF.Registers[9], 32'h12345678);
        chk("zero_reg", dut.RF.Registers[0], 32'h0);
        chk("mem_halt", pc, 32'd24);

        // fill array; reset lands on the first sw
        p = '{ei(8, 0, 8, 0), ei(8, 0, 9, 12), ei(8, 0, 10, 0),
              ei('h2B, 10, 8, 0), ei(8, 8, 8, 1), ei(8, 10, 10, 4),
              ei(5, 8, 9, -4), ej(2, 'h1C)};
        restart(p);
        run(3);
        chk("fill_pre", pc, 32'h0C);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_pc", pc, 32'h0);
        chk("mid_reset_t1", dut.RF.Registers[9], 32'h0);
        chk("mid_reset_dm0", dmw(0), 32'h12345678);
        chk("mid_reset_dm8", dmw(8), 32'h12345678);
        reset = 1'b0;
        run(60);
        chk("fill_halt", pc, 32'h1C);
        chk("fill_cnt", dut.RF.Registers[8], 32'h0000000C);
        for (int i = 0; i < 12; i++)
            chk($sformatf("fill_w%0d", i), dmw(4 * i), i);

        // control flow
        p = {};
        for (int i = 0; i < 20; i++) p.push_back(32'h0);
        p[0]  = ei(8, 0, 8, 1);
        p[1]  = ei(4, 8, 8, 1);
        p[2]  = ei(8, 0, 9, 'h77);
        p[3]  = ei(5, 8, 8, 1);
        p[4]  = ei(8, 0, 10, 'h55);
        p[5]  = ej(3, 'h40);
        p[6]  = ei(8, 0, 11, 'h33);
        p[7]  = 32'hFC000000;
        p[8]  = er(8, 8, 13, 0, 'h3F);
        p[9]  = ej(2, 'h24);
        p[16] = ei(8, 0, 12, 'h44);
        p[17] = er(31, 0, 0, 0, 'h08);
        restart(p);
        run(2);
        chk("beq_taken", pc, 32'h0C);
        run(1);
        chk("bne_fall", pc, 32'h10);
        run(2);
        chk("jal_pc", pc, 32'h40);
        chk("jal_ra", dut.RF.Registers[31], 32'h18);
        run(2);
        chk("jr_pc", pc, 32'h18);
        run(1);
        chk("after_ret", dut.RF.Registers[11], 32'h33);
        run(1);
        chk("bad_op_pc", pc, 32'h20);
        run(1);
        chk("bad_fn_pc", pc, 32'h24);
        chk("bad_fn_rd", dut.RF.Registers[13], 32'h0);
        run(5);
        chk("cf_halt", pc, 32'h24);
        chk("skipped", dut.RF.Registers[9], 32'h0);
        chk("fell_thru", dut.RF.Registers[10], 32'h55);
        chk("callee", dut.RF.Registers[12], 32'h44);

        en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
